// File: rtl/switch_out_sched_pkg.sv
// Shared types for the switch egress scheduler: byte type, FSM states and id-width helper.
package switch_pkg;
   localparam int NUM_PORTS = 4;

   typedef logic [7:0] byte_t;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} sched_state_t;

   function automatic int port_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [port_id_w(NUM_PORTS)-1:0] port_id_t;
endpackage

// File: rtl/switch_out_sched_if.sv
// Ingress streams, egress byte port and status bundle of the egress scheduler.
interface switch_out_sched_if
   import switch_pkg::*;
#(
   parameter int NUM_IN = NUM_PORTS,
   parameter int CNT_W  = 16
);
   localparam int ID_W = port_id_w(NUM_IN);

   // Ingress i transfers a byte at an edge where in_valid[i] && in_ready[i]; a valid byte is
   // held stable until taken. Egress byte transfers at an edge where port_ready && port_read.
   logic [NUM_IN-1:0]        in_valid;
   byte_t [NUM_IN-1:0]       in_data;
   logic [NUM_IN-1:0]        in_last;
   logic [NUM_IN-1:0]        in_ready;
   byte_t                    port_out;
   logic                     port_ready;
   logic                     port_read;
   logic                     grant_valid;
   logic [ID_W-1:0]          grant_id;
   logic [CNT_W-1:0]         pkt_cnt;
   sched_state_t             dbg_state;

   modport master (
      output in_valid, in_data, in_last, port_read,
      input  in_ready, port_out, port_ready, grant_valid, grant_id, pkt_cnt, dbg_state
   );

   modport slave (
      input  in_valid, in_data, in_last, port_read,
      output in_ready, port_out, port_ready, grant_valid, grant_id, pkt_cnt, dbg_state
   );
endinterface

// File: rtl/switch_out_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping around.
module rr_arbiter
   import switch_pkg::*;
#(
   parameter int NUM_IN = NUM_PORTS
) (
   input  logic [NUM_IN-1:0]             req,
   input  logic [port_id_w(NUM_IN)-1:0]  ptr,
   output logic [NUM_IN-1:0]             gnt_oh,
   output logic [port_id_w(NUM_IN)-1:0]  gnt_idx,
   output logic                          hit
);
   localparam int ID_W = port_id_w(NUM_IN);

   logic [ID_W-1:0] cand;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      hit     = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_IN);
         if (!hit && req[cand]) begin
            hit          = 1'b1;
            gnt_oh[cand] = 1'b1;
            gnt_idx      = cand;
         end
      end
   end
endmodule

// File: rtl/switch_out_sched.sv
// Egress scheduler: packet-granular round-robin over ingress streams into a one-byte output register.
module switch_out_sched
   import switch_pkg::*;
#(
   parameter int NUM_IN = NUM_PORTS,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   switch_out_sched_if.slave bus
);
   localparam int ID_W = port_id_w(NUM_IN);

   sched_state_t      state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_IN-1:0] grant_oh_q, grant_oh_d;
   logic              grant_valid_q, grant_valid_d;
   logic              port_ready_q, port_ready_d;
   byte_t             port_out_q, port_out_d;
   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

   logic [NUM_IN-1:0] arb_oh;
   logic [ID_W-1:0]   arb_idx;
   logic              arb_hit;
   logic [NUM_IN-1:0] in_ready;
   logic              space;
   logic              accept;
   logic              last_byte;

   rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
      .req     (bus.in_valid),
      .ptr     (rr_ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .hit     (arb_hit)
   );

   always_comb begin
      // The output register can take a byte if it is empty or being drained this edge.
      space     = !port_ready_q || bus.port_read;
      in_ready  = '0;
      if (state_q == BUSY && !rst) begin
         in_ready = grant_oh_q & bus.in_valid & {NUM_IN{space}};
      end
      accept    = |in_ready;
      last_byte = bus.in_last[grant_id_q];

      state_d       = state_q;
      grant_id_d    = grant_id_q;
      grant_oh_d    = grant_oh_q;
      grant_valid_d = grant_valid_q;
      rr_ptr_d      = rr_ptr_q;
      port_ready_d  = port_ready_q;
      port_out_d    = port_out_q;
      pkt_cnt_d     = pkt_cnt_q;

      if (accept) begin
         port_out_d   = bus.in_data[grant_id_q];
         port_ready_d = 1'b1;
      end else if (bus.port_read) begin
         port_ready_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (arb_hit) begin
               state_d       = BUSY;
               grant_valid_d = 1'b1;
               grant_id_d    = arb_idx;
               grant_oh_d    = arb_oh;
            end
         end
         BUSY: begin
            if (accept && last_byte) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
               pkt_cnt_d     = pkt_cnt_q + CNT_W'(1);
               rr_ptr_d      = (grant_id_q == ID_W'(NUM_IN - 1)) ? '0 : grant_id_q + ID_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_id_q    <= '0;
         grant_oh_q    <= '0;
         grant_valid_q <= 1'b0;
         rr_ptr_q      <= '0;
         port_ready_q  <= 1'b0;
         port_out_q    <= '0;
         pkt_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         grant_oh_q    <= grant_oh_d;
         grant_valid_q <= grant_valid_d;
         rr_ptr_q      <= rr_ptr_d;
         port_ready_q  <= port_ready_d;
         port_out_q    <= port_out_d;
         pkt_cnt_q     <= pkt_cnt_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.port_out    = port_out_q;
   assign bus.port_ready  = port_ready_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.pkt_cnt     = pkt_cnt_q;
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_switch_out_sched.sv
// Bench for switch_out_sched: vector table, directed corner sequences and random traffic vs a packet-level model.
module tb_switch_out_sched;
   import switch_pkg::*;

   localparam int N  = 4;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst;
   logic rst2;
   always #5 clk = ~clk;

   switch_out_sched_if #(.NUM_IN(N), .CNT_W(CW)) bus ();
   switch_out_sched_if #(.NUM_IN(N), .CNT_W(2))  bus2 ();

   switch_out_sched #(.NUM_IN(N), .CNT_W(CW)) dut  (.clk(clk), .rst(rst),  .bus(bus));
   switch_out_sched #(.NUM_IN(N), .CNT_W(2))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

   int checks = 0;
   int errors = 0;

   // Reference model: a busy flag, the granted port, a rotating start index and the
   // egress register seen as a queue of at most one byte.
   bit         m_busy;
   int         m_g;
   int         m_rr;
   int         m_cnt;
   logic [7:0] m_pout;
   logic [7:0] exp_q[$];
   int         grant_log[$];

   logic [8:0] src_q[N][$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_rx[$];
   int         exp_gl[$];
   logic [N-1:0] samp_ir = '0;
   logic       samp_take = 1'b0;
   logic [7:0] samp_out;
   int         last_cycles;

   typedef struct {
      logic [N-1:0] v;
      logic [7:0]   d;
      logic         l;
      logic         rd;
      logic         gv;
      logic [1:0]   gid;
      logic         pr;
      logic [7:0]   po;
      logic [N-1:0] ir;
      logic [15:0]  cnt;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic add_pkt(input int port, input int len, input logic [7:0] base);
      for (int b = 0; b < len; b++) src_q[port].push_back({(b == len - 1), 8'(base + 8'(b))});
   endtask

   task automatic drive(input logic rd, input logic [N-1:0] stall);
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() != 0 && !stall[i]) begin
            bus.in_valid[i] = 1'b1;
            bus.in_data[i]  = src_q[i][0][7:0];
            bus.in_last[i]  = src_q[i][0][8];
         end else begin
            bus.in_valid[i] = 1'b0;
            bus.in_data[i]  = 8'($urandom);
            bus.in_last[i]  = 1'b0;
         end
      end
      bus.port_read = rd;
   endtask

   task automatic sample();
      logic [N-1:0] exp_ir;
      @(negedge clk);
      samp_ir   = bus.in_ready;
      samp_take = bus.port_ready & bus.port_read;
      samp_out  = bus.port_out;
      exp_ir    = '0;
      if (!rst && m_busy && bus.in_valid[m_g] && (exp_q.size() == 0 || bus.port_read))
         exp_ir[m_g] = 1'b1;
      check("in_ready",    32'(bus.in_ready),    32'(exp_ir));
      check("port_ready",  32'(bus.port_ready),  (exp_q.size() != 0) ? 32'd1 : 32'd0);
      check("port_out",    32'(bus.port_out),    32'(m_pout));
      check("grant_valid", 32'(bus.grant_valid), 32'(m_busy));
      check("grant_id",    32'(bus.grant_id),    32'(m_g));
      check("pkt_cnt",     32'(bus.pkt_cnt),     32'(m_cnt));
   endtask

   task automatic advance();
      bit acc;
      bit found;
      int k;
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_g = 0; m_rr = 0; m_cnt = 0; m_pout = '0;
         exp_q.delete();
      end else begin
         for (int i = 0; i < N; i++)
            if (samp_ir[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         if (samp_take) rx_q.push_back(samp_out);
         acc = m_busy && bus.in_valid[m_g] && (exp_q.size() == 0 || bus.port_read);
         if (exp_q.size() != 0 && bus.port_read) void'(exp_q.pop_front());
         if (m_busy) begin
            if (acc) begin
               exp_q.push_back(bus.in_data[m_g]);
               m_pout = bus.in_data[m_g];
               if (bus.in_last[m_g]) begin
                  m_cnt  = (m_cnt + 1) % (1 << CW);
                  m_rr   = (m_g + 1) % N;
                  m_busy = 0;
               end
            end
         end else begin
            found = 0;
            for (int j = 0; j < N; j++) begin
               k = (m_rr + j) % N;
               if (!found && bus.in_valid[k]) begin
                  found = 1; m_busy = 1; m_g = k;
                  grant_log.push_back(k);
               end
            end
         end
      end
      #1;
   endtask

   task automatic cycle(input logic rd, input logic [N-1:0] stall);
      drive(rd, stall);
      sample();
      advance();
   endtask

   task automatic run_pkts(input int budget, input bit rnd);
      int n;
      n = 0;
      while ((pending() || m_busy) && n < budget) begin
         if (rnd) cycle(($urandom_range(0, 3) != 0), N'($urandom_range(0, (1 << N) - 1)));
         else     cycle(1'b1, '0);
         n++;
      end
      last_cycles = n;
      check("drain_pending", 32'(pending() || m_busy), 32'd0);
      cycle(1'b1, '0);
   endtask

   task automatic check_rx(input string name);
      check({name, "_len"}, rx_q.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++) check(name, 32'(rx_q[i]), 32'(exp_rx[i]));
   endtask

   task automatic check_gl(input string name);
      check({name, "_len"}, grant_log.size(), exp_gl.size());
      for (int i = 0; i < exp_gl.size() && i < grant_log.size(); i++) check(name, grant_log[i], exp_gl[i]);
   endtask

   task automatic clear_logs();
      rx_q.delete();
      grant_log.delete();
   endtask

   initial begin
      int n;
      int acc2;
      int sent;
      int port;
      int len;

      tbl[0] = '{v:4'b0010, d:8'hA1, l:1'b0, rd:1'b1, gv:1'b0, gid:2'd0, pr:1'b0, po:8'h00, ir:4'b0000, cnt:16'd0};
      tbl[1] = '{v:4'b0010, d:8'hA1, l:1'b0, rd:1'b1, gv:1'b1, gid:2'd1, pr:1'b0, po:8'h00, ir:4'b0010, cnt:16'd0};
      tbl[2] = '{v:4'b0010, d:8'hA2, l:1'b0, rd:1'b1, gv:1'b1, gid:2'd1, pr:1'b1, po:8'hA1, ir:4'b0010, cnt:16'd0};
      tbl[3] = '{v:4'b0010, d:8'hA3, l:1'b1, rd:1'b1, gv:1'b1, gid:2'd1, pr:1'b1, po:8'hA2, ir:4'b0010, cnt:16'd0};
      tbl[4] = '{v:4'b0000, d:8'h00, l:1'b0, rd:1'b1, gv:1'b0, gid:2'd1, pr:1'b1, po:8'hA3, ir:4'b0000, cnt:16'd1};
      tbl[5] = '{v:4'b0000, d:8'h00, l:1'b0, rd:1'b1, gv:1'b0, gid:2'd1, pr:1'b0, po:8'hA3, ir:4'b0000, cnt:16'd1};

      rst2 = 1'b1;
      bus2.in_valid = '0; bus2.in_data = '0; bus2.in_last = '0; bus2.port_read = 1'b0;

      // Reset with random inputs and port_read held high
      rst = 1'b1;
      bus.in_valid = '0; bus.in_data = '0; bus.in_last = '0; bus.port_read = 1'b1;
      advance();
      repeat (2) begin
         bus.in_valid  = N'($urandom);
         bus.in_data   = 32'($urandom);
         bus.in_last   = N'($urandom);
         bus.port_read = 1'b1;
         sample();
         advance();
      end
      rst = 1'b0;

      // Single packet at full rate from ingress 1
      for (int r = 0; r < 6; r++) begin
         bus.in_valid  = tbl[r].v;
         bus.in_data   = '0;
         bus.in_data[1] = tbl[r].d;
         bus.in_last   = {2'b00, tbl[r].l, 1'b0};
         bus.port_read = tbl[r].rd;
         sample();
         check("tbl_grant_valid", 32'(bus.grant_valid), 32'(tbl[r].gv));
         check("tbl_grant_id",    32'(bus.grant_id),    32'(tbl[r].gid));
         check("tbl_port_ready",  32'(bus.port_ready),  32'(tbl[r].pr));
         check("tbl_port_out",    32'(bus.port_out),    32'(tbl[r].po));
         check("tbl_in_ready",    32'(bus.in_ready),    32'(tbl[r].ir));
         check("tbl_pkt_cnt",     32'(bus.pkt_cnt),     32'(tbl[r].cnt));
         advance();
      end

      // Round-robin fairness from a fresh pointer
      rst = 1'b1; cycle(1'b1, '0); rst = 1'b0;
      clear_logs();
      add_pkt(0, 2, 8'h10); add_pkt(0, 2, 8'h20);
      add_pkt(2, 2, 8'h30); add_pkt(2, 2, 8'h40);
      run_pkts(40, 0);
      check("rr_cycles", last_cycles, 12);
      check("rr_pkt_cnt", 32'(bus.pkt_cnt), 32'd4);
      exp_gl = {0, 2, 0, 2};
      check_gl("rr_order");
      exp_rx = {8'h10, 8'h11, 8'h30, 8'h31, 8'h20, 8'h21, 8'h40, 8'h41};
      check_rx("rr_bytes");

      // Back-pressure after byte 2 of a 4-byte packet
      clear_logs();
      add_pkt(3, 4, 8'h51);
      n = 0;
      while (!(exp_q.size() != 0 && exp_q[0] == 8'h52) && n < 10) begin
         cycle(1'b1, '0);
         n++;
      end
      check("bp_reach", 32'(bus.port_out), 32'h52);
      repeat (5) begin
         drive(1'b0, '0);
         sample();
         check("bp_hold_out",   32'(bus.port_out),   32'h52);
         check("bp_hold_ready", 32'(bus.port_ready), 32'd1);
         check("bp_in_ready",   32'(bus.in_ready),   32'd0);
         advance();
      end
      run_pkts(20, 0);
      exp_rx = {8'h51, 8'h52, 8'h53, 8'h54};
      check_rx("bp_bytes");

      // Spurious read while idle, then an ingress stall mid-packet
      clear_logs();
      repeat (3) cycle(1'b1, '0);
      check("spur_port_ready", 32'(bus.port_ready), 32'd0);
      check("spur_grant_valid", 32'(bus.grant_valid), 32'd0);
      add_pkt(2, 4, 8'h61);
      n = 0;
      while (!m_busy && n < 5) begin cycle(1'b1, '0); n++; end
      add_pkt(0, 1, 8'h70);
      cycle(1'b1, '0);
      repeat (3) begin
         drive(1'b1, 4'b0100);
         sample();
         check("stall_grant_valid", 32'(bus.grant_valid), 32'd1);
         check("stall_grant_id",    32'(bus.grant_id),    32'd2);
         check("stall_in_ready",    32'(bus.in_ready),    32'd0);
         advance();
      end
      run_pkts(30, 0);
      exp_gl = {2, 0};
      check_gl("stall_order");
      exp_rx = {8'h61, 8'h62, 8'h63, 8'h64, 8'h70};
      check_rx("stall_bytes");

      // Reset after byte 1 of a 3-byte packet
      clear_logs();
      add_pkt(1, 3, 8'h81);
      n = 0;
      while (src_q[1].size() != 2 && n < 6) begin cycle(1'b1, '0); n++; end
      rst = 1'b1; cycle(1'b1, '0); rst = 1'b0;
      src_q[1].delete();
      clear_logs();
      check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
      check("rst_port_ready", 32'(bus.port_ready), 32'd0);
      add_pkt(1, 1, 8'h91); add_pkt(3, 1, 8'hA1);
      run_pkts(20, 0);
      exp_gl = {1, 3};
      check_gl("rst_order");
      exp_rx = {8'h91, 8'hA1};
      check_rx("rst_bytes");
      check("rst_pkt_cnt_after", 32'(bus.pkt_cnt), 32'd2);

      // Random traffic against the model
      clear_logs();
      sent = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            port = $urandom_range(0, N - 1);
            if (src_q[port].size() < 10) begin
               len = $urandom_range(1, 5);
               add_pkt(port, len, 8'($urandom_range(0, 255)));
               sent += len;
            end
         end
         cycle(($urandom_range(0, 3) != 0), N'($urandom_range(0, (1 << N) - 1)));
      end
      run_pkts(400, 1);
      check("rand_bytes_len", rx_q.size(), sent);

      // Counter wrap on a 2-bit counter instance
      @(negedge clk);
      check("wrap_reset_cnt", 32'(bus2.pkt_cnt), 32'd0);
      @(posedge clk); #1;
      rst2 = 1'b0;
      bus2.in_valid = 4'b0001; bus2.in_last = 4'b0001; bus2.in_data = '0; bus2.port_read = 1'b1;
      acc2 = 0; n = 0;
      while (acc2 < 5 && n < 40) begin
         @(negedge clk);
         if (bus2.in_ready[0]) acc2++;
         @(posedge clk); #1;
         if (acc2 == 5) bus2.in_valid = '0;
         n++;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("wrap_accepts", acc2, 5);
      check("wrap_pkt_cnt", 32'(bus2.pkt_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
